// File: rtl/nbody_pkg.sv
// Shared types and pipeline latencies for the n-body scheduler, datapath and bench.
package nbody_pkg;
  localparam int BODY_ADDR_WIDTH = 9;
  localparam int GAP_WIDTH       = 32;
  localparam int LATENCY         = 122;
  localparam int UPD_LATENCY     = 31;
  localparam int CNT_WIDTH       = 8;

  typedef logic [BODY_ADDR_WIDTH-1:0] body_idx_t;
  typedef logic [BODY_ADDR_WIDTH:0]   body_cnt_t;
  typedef logic [GAP_WIDTH-1:0]       step_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    UPDATE,
    UDRAIN,
    STEP_END
  } sched_state_t;

  function automatic body_cnt_t widen(input body_idx_t x);
    return {1'b0, x};
  endfunction
endpackage

// File: rtl/nbody_sched_if.sv
// Register-decode and datapath-facing signals of the n-body scheduler.
interface nbody_sched_if;
  import nbody_pkg::*;

  logic      go;
  body_cnt_t n_bodies;
  step_t     gap;
  logic      busy;
  logic      done;
  logic      issue_valid;
  body_idx_t issue_i;
  body_idx_t issue_j;
  logic      issue_first;
  logic      issue_last;
  logic      upd_valid;
  body_idx_t upd_idx;
  logic      buf_sel;
  step_t     step_count;

  modport master (
    output go, n_bodies, gap,
    input  busy, done, issue_valid, issue_i, issue_j, issue_first, issue_last,
    input  upd_valid, upd_idx, buf_sel, step_count
  );

  modport slave (
    input  go, n_bodies, gap,
    output busy, done, issue_valid, issue_i, issue_j, issue_first, issue_last,
    output upd_valid, upd_idx, buf_sel, step_count
  );
endinterface

// File: rtl/nbody_pair_gen.sv
// Nested i/j pair counter over all ordered pairs with i != j, one pair per advance.
module nbody_pair_gen
  import nbody_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      advance,
  input  body_cnt_t n,
  output logic      valid,
  output body_idx_t i,
  output body_idx_t j,
  output logic      first,
  output logic      last,
  output logic      final_pair
);
  body_cnt_t n_m1;
  body_cnt_t last_j;
  logic      i_is_top;

  // The top row skips the diagonal at its end, so its last source is n-2.
  always_comb begin
    n_m1       = n - body_cnt_t'(1);
    i_is_top   = (widen(i) == n_m1);
    last_j     = i_is_top ? (n - body_cnt_t'(2)) : n_m1;
    first      = (j == ((i == '0) ? body_idx_t'(1) : body_idx_t'(0)));
    last       = (widen(j) == last_j);
    final_pair = valid && last && i_is_top;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      i     <= '0;
      j     <= '0;
    end else if (start) begin
      valid <= (n >= body_cnt_t'(2));
      i     <= '0;
      j     <= body_idx_t'(1);
    end else if (advance && valid) begin
      if (last) begin
        if (i_is_top) begin
          valid <= 1'b0;
        end else begin
          i <= i + body_idx_t'(1);
          j <= '0;
        end
      end else if ((j + body_idx_t'(1)) == i) begin
        j <= j + body_idx_t'(2);
      end else begin
        j <= j + body_idx_t'(1);
      end
    end
  end
endmodule

// File: rtl/nbody_sched.sv
// Timestep sequencer: force-pair issue, pipeline drain, body update, buffer flip.
module nbody_sched
  import nbody_pkg::*;
(
  input logic          clk,
  input logic          rst,
  nbody_sched_if.slave bus
);
  sched_state_t         state, state_next;
  body_cnt_t            n_reg;
  step_t                steps_reg;
  step_t                step_count;
  logic [CNT_WIDTH-1:0] cnt;
  body_idx_t            upd_idx;
  logic                 busy, done, buf_sel, start_pend;
  logic                 accept, pair_start, pair_adv, step_done, run_done;
  logic                 upd_end, step_last;
  logic                 pg_valid, pg_first, pg_last, pg_final;
  body_idx_t            pg_i, pg_j;

  nbody_pair_gen u_pair_gen (
    .clk        (clk),
    .rst        (rst),
    .start      (pair_start),
    .advance    (pair_adv),
    .n          (n_reg),
    .valid      (pg_valid),
    .i          (pg_i),
    .j          (pg_j),
    .first      (pg_first),
    .last       (pg_last),
    .final_pair (pg_final)
  );

  assign upd_end   = (widen(upd_idx) == (n_reg - body_cnt_t'(1)));
  assign step_last = ((step_count + step_t'(1)) == steps_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // An accepted go spends one cycle latching parameters before ISSUE starts.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    pair_start = 1'b0;
    pair_adv   = 1'b0;
    step_done  = 1'b0;
    run_done   = 1'b0;
    case (state)
      IDLE: begin
        if (start_pend) begin
          state_next = ISSUE;
          pair_start = 1'b1;
        end else if (bus.go) begin
          accept = 1'b1;
        end
      end
      ISSUE: begin
        pair_adv = pg_valid;
        if (!pg_valid || pg_final) state_next = DRAIN;
      end
      DRAIN:  if (cnt == CNT_WIDTH'(1)) state_next = UPDATE;
      UPDATE: if (upd_end) state_next = UDRAIN;
      UDRAIN: if (cnt == CNT_WIDTH'(1)) state_next = STEP_END;
      STEP_END: begin
        step_done = 1'b1;
        if (step_last) begin
          state_next = IDLE;
          run_done   = 1'b1;
        end else begin
          state_next = ISSUE;
          pair_start = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg      <= '0;
      steps_reg  <= '0;
      step_count <= '0;
      cnt        <= '0;
      upd_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      buf_sel    <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      if (accept) begin
        n_reg      <= bus.n_bodies;
        steps_reg  <= (bus.gap == '0) ? step_t'(1) : bus.gap;
        step_count <= '0;
        done       <= (bus.n_bodies == '0);
        busy       <= (bus.n_bodies != '0);
        start_pend <= (bus.n_bodies != '0);
      end
      if (pair_start) start_pend <= 1'b0;

      if (state != DRAIN && state_next == DRAIN)        cnt <= CNT_WIDTH'(LATENCY);
      else if (state != UDRAIN && state_next == UDRAIN) cnt <= CNT_WIDTH'(UPD_LATENCY);
      else if (cnt != '0)                               cnt <= cnt - CNT_WIDTH'(1);

      if (state != UPDATE && state_next == UPDATE) upd_idx <= '0;
      else if (state == UPDATE && !upd_end)        upd_idx <= upd_idx + body_idx_t'(1);

      if (step_done) begin
        step_count <= step_count + step_t'(1);
        buf_sel    <= ~buf_sel;
      end
      if (run_done) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.issue_valid = (state == ISSUE) && pg_valid;
  assign bus.issue_i     = pg_i;
  assign bus.issue_j     = pg_j;
  assign bus.issue_first = (state == ISSUE) && pg_valid && pg_first;
  assign bus.issue_last  = (state == ISSUE) && pg_valid && pg_last;
  assign bus.upd_valid   = (state == UPDATE);
  assign bus.upd_idx     = upd_idx;
  assign bus.buf_sel     = buf_sel;
  assign bus.step_count  = step_count;
endmodule

// File: tb/tb_nbody_sched.sv
// Randomised and directed bench for nbody_sched against a loop-based reference model.
module tb_nbody_sched;
  import nbody_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nbody_sched_if bus();
  nbody_sched dut (.clk(clk), .rst(rst), .bus(bus));

  logic [65:0] outs;
  assign outs = {bus.busy, bus.done, bus.issue_valid, bus.issue_i, bus.issue_j,
                 bus.issue_first, bus.issue_last, bus.upd_valid, bus.upd_idx,
                 bus.buf_sel, bus.step_count};

  int checks = 0;
  int failures = 0;
  logic model_buf;
  logic [19:0] obs_pairs[$], exp_pairs[$];
  logic [9:0]  obs_upd[$], exp_upd[$];
  int done_cycle, exp_done, exp_steps, exp_count;
  logic busy_seen, busy_at_done, end_buf, exp_end_buf;
  logic [31:0] end_step_count;

  // Expected stream built straight from the pair/update ordering rules.
  task automatic build_expected(input int n, input logic [31:0] gap, input int pair_cap);
    logic b;
    int per;
    exp_pairs.delete();
    exp_upd.delete();
    exp_steps = (gap == 0) ? 1 : int'(gap);
    b = model_buf;
    if (n == 0) begin
      exp_done = 0;
      exp_count = 0;
      exp_end_buf = b;
      return;
    end
    for (int s = 0; s < exp_steps; s++) begin
      for (int i = 0; i < n; i++) begin
        int fj, lj;
        fj = (i == 0) ? 1 : 0;
        lj = (i == n - 1) ? n - 2 : n - 1;
        for (int j = 0; j < n; j++)
          if (j != i && exp_pairs.size() < pair_cap)
            exp_pairs.push_back({9'(i), 9'(j), (j == fj), (j == lj)});
      end
      for (int u = 0; u < n; u++) exp_upd.push_back({b, 9'(u)});
      b = ~b;
    end
    per = ((n == 1) ? 1 : n * (n - 1)) + LATENCY + n + UPD_LATENCY + 1;
    exp_done = 1 + exp_steps * per;
    exp_count = exp_steps;
    exp_end_buf = b;
  endtask

  task automatic run_capture(input int n, input logic [31:0] gap, input int max_cycles,
                             input int go_again_at);
    obs_pairs.delete();
    obs_upd.delete();
    done_cycle = -1;
    busy_seen = 1'b0;
    busy_at_done = 1'b0;
    @(negedge clk);
    bus.n_bodies = 10'(n);
    bus.gap = gap;
    bus.go = 1'b1;
    @(posedge clk);
    #1 bus.go = 1'b0;
    for (int k = 0; k <= max_cycles; k++) begin
      if (k > 0) begin
        bus.go = (k == go_again_at);
        if (k == go_again_at) bus.n_bodies = 10'd5;
        @(posedge clk);
        #1;
      end
      busy_seen = busy_seen | bus.busy;
      if (bus.issue_valid)
        obs_pairs.push_back({bus.issue_i, bus.issue_j, bus.issue_first, bus.issue_last});
      if (bus.upd_valid) obs_upd.push_back({bus.buf_sel, bus.upd_idx});
      end_buf = bus.buf_sel;
      end_step_count = bus.step_count;
      if (bus.done) begin
        done_cycle = k;
        busy_at_done = bus.busy;
        break;
      end
    end
    bus.go = 1'b0;
  endtask

  function automatic int pair_diff();
    int m = (obs_pairs.size() < exp_pairs.size()) ? obs_pairs.size() : exp_pairs.size();
    for (int k = 0; k < m; k++) if (obs_pairs[k] !== exp_pairs[k]) return k;
    return (obs_pairs.size() == exp_pairs.size()) ? -1 : m;
  endfunction

  function automatic int upd_diff();
    int m = (obs_upd.size() < exp_upd.size()) ? obs_upd.size() : exp_upd.size();
    for (int k = 0; k < m; k++) if (obs_upd[k] !== exp_upd[k]) return k;
    return (obs_upd.size() == exp_upd.size()) ? -1 : m;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.go = 1'b0;
    bus.n_bodies = '0;
    bus.gap = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_values got %h expected 0", outs);
    end
    @(negedge clk) rst = 1'b0;
    model_buf = 1'b0;
  endtask

  task automatic test_pair_stream();
    int ns[4] = '{3, 1, 0, 2};
    int gs[4] = '{2, 1, 4, 0};
    int d;
    for (int t = 0; t < 4; t++) begin
      build_expected(ns[t], 32'(gs[t]), 1 << 30);
      run_capture(ns[t], 32'(gs[t]), exp_done + 5, -1);
      checks++;
      d = pair_diff();
      if (d >= 0) begin
        failures++;
        $display("[TB] FAIL stream_pairs n=%0d at #%0d got count %0d expected count %0d",
                 ns[t], d, obs_pairs.size(), exp_pairs.size());
      end
      checks++;
      d = upd_diff();
      if (d >= 0) begin
        failures++;
        $display("[TB] FAIL stream_upd n=%0d at #%0d got count %0d expected count %0d",
                 ns[t], d, obs_upd.size(), exp_upd.size());
      end
      checks++;
      if (done_cycle !== exp_done) begin
        failures++;
        $display("[TB] FAIL stream_done n=%0d got cycle %0d expected %0d", ns[t], done_cycle, exp_done);
      end
      checks++;
      if ({end_step_count, end_buf, busy_seen, busy_at_done} !==
          {32'(exp_count), exp_end_buf, (ns[t] != 0), 1'b0}) begin
        failures++;
        $display("[TB] FAIL stream_status n=%0d got steps=%0d buf=%b busy_seen=%b busy_at_done=%b expected steps=%0d buf=%b busy_seen=%b busy_at_done=0",
                 ns[t], end_step_count, end_buf, busy_seen, busy_at_done, exp_count, exp_end_buf, (ns[t] != 0));
      end
      model_buf = exp_end_buf;
    end
  endtask

  task automatic test_go_ignored();
    int d;
    build_expected(3, 32'd2, 1 << 30);
    run_capture(3, 32'd2, exp_done + 5, 50);
    checks++;
    d = pair_diff();
    if (d >= 0) begin
      failures++;
      $display("[TB] FAIL go_ignored_pairs at #%0d got count %0d expected count %0d",
               d, obs_pairs.size(), exp_pairs.size());
    end
    checks++;
    if (done_cycle !== exp_done) begin
      failures++;
      $display("[TB] FAIL go_ignored_done got cycle %0d expected %0d", done_cycle, exp_done);
    end
    model_buf = exp_end_buf;
  endtask

  task automatic test_reset_mid_update();
    int d;
    run_capture(3, 32'd2, 130, -1);
    checks++;
    if (obs_upd.size() != 2) begin
      failures++;
      $display("[TB] FAIL mid_update_reach got %0d updates expected 2", obs_upd.size());
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset got %h expected 0", outs);
    end
    @(negedge clk) rst = 1'b0;
    model_buf = 1'b0;
    build_expected(2, 32'd1, 1 << 30);
    run_capture(2, 32'd1, exp_done + 5, -1);
    checks++;
    d = upd_diff();
    if (d >= 0) begin
      failures++;
      $display("[TB] FAIL post_reset_upd at #%0d got %h expected %h", d,
               (d < obs_upd.size()) ? obs_upd[d] : 10'h0, (d < exp_upd.size()) ? exp_upd[d] : 10'h0);
    end
    checks++;
    if ({done_cycle, end_buf} !== {exp_done, exp_end_buf}) begin
      failures++;
      $display("[TB] FAIL post_reset_run got done=%0d buf=%b expected done=%0d buf=%b",
               done_cycle, end_buf, exp_done, exp_end_buf);
    end
    model_buf = exp_end_buf;
  endtask

  task automatic test_wide_count();
    int d;
    build_expected(512, 32'd1, 700);
    run_capture(512, 32'd1, 700, -1);
    checks++;
    d = pair_diff();
    if (d >= 0) begin
      failures++;
      $display("[TB] FAIL wide_pairs at #%0d got %h expected %h (counts %0d/%0d)", d,
               (d < obs_pairs.size()) ? obs_pairs[d] : 20'h0,
               (d < exp_pairs.size()) ? exp_pairs[d] : 20'h0, obs_pairs.size(), exp_pairs.size());
    end
    checks++;
    if ({busy_seen, done_cycle} !== {1'b1, -1}) begin
      failures++;
      $display("[TB] FAIL wide_status got busy=%b done_cycle=%0d expected busy=1 done_cycle=-1",
               busy_seen, done_cycle);
    end
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_buf = 1'b0;
  endtask

  task automatic test_random();
    int n, d;
    logic [31:0] g;
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(0, 9);
      g = 32'($urandom_range(0, 3));
      build_expected(n, g, 1 << 30);
      run_capture(n, g, exp_done + 5, -1);
      checks++;
      d = pair_diff();
      if (d >= 0) begin
        failures++;
        $display("[TB] FAIL random_pairs n=%0d gap=%0d at #%0d counts %0d/%0d", n, g, d,
                 obs_pairs.size(), exp_pairs.size());
      end
      checks++;
      d = upd_diff();
      if (d >= 0) begin
        failures++;
        $display("[TB] FAIL random_upd n=%0d gap=%0d at #%0d counts %0d/%0d", n, g, d,
                 obs_upd.size(), exp_upd.size());
      end
      checks++;
      if ({done_cycle, end_step_count, end_buf} !== {exp_done, 32'(exp_count), exp_end_buf}) begin
        failures++;
        $display("[TB] FAIL random_done n=%0d gap=%0d got done=%0d steps=%0d buf=%b expected done=%0d steps=%0d buf=%b",
                 n, g, done_cycle, end_step_count, end_buf, exp_done, exp_count, exp_end_buf);
      end
      model_buf = exp_end_buf;
    end
  endtask

  initial begin
    test_reset();
    test_pair_stream();
    test_go_ignored();
    test_reset_mid_update();
    test_wide_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nbody_sched.md
Name: nbody_sched

Overview:
- Sequencing controller for the n-body force/update datapath.
- On a host GO it runs `gap` timesteps. Each timestep has two phases:
  - Force phase: streams every ordered body pair (i, j), with i≠j, into the fully pipelined force pipeline.
  - Update phase: streams every body index into the position/velocity update unit.
- Between timesteps it waits out pipeline latency and flips the position double-buffer select.
- Sits between the Avalon register decode (GO / N_BODIES / GAP registers, DONE readback) and the datapath.

Parameters:
- BODY_ADDR_WIDTH, 9, width of body index; max 512 bodies.
- LATENCY, 122, force pipeline latency in cycles (Add+Mult+Add+InvSqrt+3×Mult).
- UPD_LATENCY, 31, update unit latency in cycles (Mult+Add).
- GAP_WIDTH, 32, width of timestep count.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- go  in  1  one-cycle start pulse from GO register write
- n_bodies  in  BODY_ADDR_WIDTH+1  body count, sampled on accepted go
- gap  in  GAP_WIDTH  timesteps per run, sampled on accepted go
- busy  out  1  run in progress
- done  out  1  sticky run-complete flag (DONE readback)
- issue_valid  out  1  pair presented to force pipeline this cycle
- issue_i  out  BODY_ADDR_WIDTH  target body
- issue_j  out  BODY_ADDR_WIDTH  source body
- issue_first  out  1  first pair for this issue_i (accumulator clear)
- issue_last  out  1  last pair for this issue_i (accumulator commit)
- upd_valid  out  1  body index presented to update unit
- upd_idx  out  BODY_ADDR_WIDTH  body being updated
- buf_sel  out  1  position buffer read by force phase; update writes !buf_sel
- step_count  out  GAP_WIDTH  completed timesteps in current run

Behaviour:
- Reset values: all outputs 0; state IDLE. Asynchronous reset mid-run aborts immediately; no partial flags survive.
- States: IDLE, ISSUE, DRAIN, UPDATE, UDRAIN, STEP_END, all registered Moore outputs.
- Go handling:
  - go is accepted only in IDLE; go while busy is ignored.
  - Accepted go latches n and steps = (gap==0 ? 1 : gap).
  - It clears done and step_count, sets busy, and enters ISSUE next cycle.
  - Exception: n==0 goes straight to done=1, busy=0, with no issues.
- ISSUE:
  - One pair per cycle; i outer loop 0..n-1, j inner loop 0..n-1, skipping j==i with no bubble.
  - issue_first is on the first j of each i (j=0, or j=1 when i=0); issue_last is on the final j of each i.
  - After the pair (n-1, n-2), go to DRAIN.
  - Exactly n(n-1) issue cycles. n==1 issues nothing: ISSUE lasts 1 cycle with issue_valid=0.
- DRAIN: counter loaded with LATENCY, counts LATENCY cycles, then UPDATE.
- UPDATE: upd_valid high for n cycles, upd_idx 0..n-1; then UDRAIN.
- UDRAIN: UPD_LATENCY cycles, then STEP_END.
- STEP_END (1 cycle):
  - buf_sel toggles and step_count increments.
  - If step_count+1 == steps: next state IDLE, busy=0, done=1.
  - Otherwise: next state ISSUE.
- Cycles per step: n(n-1) + LATENCY + n + UPD_LATENCY + 1 (the n(n-1) term counts as 1 when n==1). done rises 1 + steps×(per-step) cycles after the go-accept edge.
- buf_sel is not reset by go; it persists across runs and is reset only by rst.
- Counter widths: the pair counter i,j uses BODY_ADDR_WIDTH bits; n uses BODY_ADDR_WIDTH+1 bits so that n=512 is representable.
- done stays high until the next accepted go or rst.

Decomposition:
- Package nbody_pkg:
  - state enum sched_state_t.
  - localparams LATENCY and UPD_LATENCY, shared with the datapath and the bench.
  - body_idx_t typedef.
- Sub-module nbody_pair_gen: i/j nested counter with skip-diagonal and first/last flags; start/advance/last handshake.
- Phase FSM and latency counters stay in nbody_sched.

Test Plan:
- n=3, gap=2, go → pairs (0,1)(0,2)(1,0)(1,2)(2,0)(2,1), each step. First flags on (0,1)(1,0)(2,0); last flags on (0,2)(1,2)(2,1). upd_idx 0,1,2. buf_sel 0→1→0. step_count=2. done at cycle 327.
- n=1, gap=1 → no issue_valid, one upd_valid for idx 0, done at cycle 1+(1+122+1+31+1)=157.
- n=0 → done next cycle, busy never high. gap=0 with n=2 → exactly one step run, done at 1+(2+122+2+31+1)=159.
- go pulsed again during DRAIN → ignored: pair sequence and done timing are unchanged.
- rst asserted mid-UPDATE → all outputs 0 asynchronously. A subsequent go runs cleanly from buf_sel=0.
- n=512, gap=1 → 261632 issue cycles. Last pair is (511,510) with issue_last. No index wrap; upd_idx ends at 511.
